// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl
// Load/store controller that sits in front of a word-addressed data memory.
// The memory has a synchronous read with one cycle of latency, writes whole
// words only, and returns the old word on a write cycle.
// The controller:
//   - turns byte addresses into word indices,
//   - does read-modify-write for byte and halfword stores,
//   - sign/zero-extends load data,
//   - rejects misaligned or illegal requests without touching memory.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   req_valid/ready   request handshake; ready is high only when idle
//   req_we            1 = store, 0 = load
//   req_funct3        RV32I width/sign encoding
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_err          misaligned/illegal flag, qualified by resp_valid
//   mem_address       word index to memory
//   mem_write_data    word written to memory
//   mem_write_enable  memory write strobe
//   mem_read_data     registered memory read data
module lsu_mem_ctrl #(
    parameter int ADDR_WORDS_LOG2 = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    // Byte-address bits that matter; everything above aliases.
    localparam int AW = ADDR_WORDS_LOG2 + 2;

    typedef enum logic [2:0] {IDLE, RD, LDRET, MERGE, WR} state_e;

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q, resp_err_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;

    logic          accept;
    logic          req_err;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data;
    logic [31:0]   merge_data;
    logic          addr_unused;

    assign addr_unused = ^req_addr[31:AW];
    assign accept      = req_valid && (state_q == IDLE);

    // Request legality, evaluated on the live inputs at accept time.
    // Store funct3 011 has no RV32I meaning and is treated as illegal too.
    always_comb begin
        req_err = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000:  req_err = 1'b0;
                3'b001:  req_err = req_addr[0];
                3'b010:  req_err = |req_addr[1:0];
                default: req_err = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b100: req_err = 1'b0;
                3'b001, 3'b101: req_err = req_addr[0];
                3'b010:         req_err = |req_addr[1:0];
                default:        req_err = 1'b1;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. SW skips the read since it overwrites the whole word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !req_err) begin
                    state_d = (req_we && req_funct3 == 3'b010) ? WR : RD;
                end
            end
            RD:      state_d = we_q ? MERGE : LDRET;
            LDRET:   state_d = IDLE;
            MERGE:   state_d = IDLE;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state, so reset kills the write strobe at once.
    always_comb begin
        req_ready        = (state_q == IDLE);
        mem_write_enable = (state_q == MERGE) || (state_q == WR);
        mem_address      = {{(32 - ADDR_WORDS_LOG2){1'b0}}, addr_q[AW-1:2]};
        mem_write_data   = (state_q == MERGE) ? merge_data : wdata_q;
    end

    // Lane extraction and extension for loads.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = mem_read_data[7:0];
            2'd1:    byte_sel = mem_read_data[15:8];
            2'd2:    byte_sel = mem_read_data[23:16];
            default: byte_sel = mem_read_data[31:24];
        endcase
        half_sel = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = mem_read_data;
        endcase
    end

    // Lane replacement for SB/SH read-modify-write.
    always_comb begin
        merge_data = mem_read_data;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merge_data[7:0]   = wdata_q[7:0];
                2'd1:    merge_data[15:8]  = wdata_q[7:0];
                2'd2:    merge_data[23:16] = wdata_q[7:0];
                default: merge_data[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merge_data[31:16] = wdata_q[15:0];
        end else begin
            merge_data[15:0] = wdata_q[15:0];
        end
    end

    // Request latch and response generation. Errors respond straight
    // from IDLE; every other response leaves the last active state.
    always_comb begin
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        if (accept) begin
            we_d     = req_we;
            funct3_d = req_funct3;
            addr_d   = req_addr[AW-1:0];
            wdata_d  = req_wdata;
        end
        case (state_q)
            IDLE: begin
                if (accept && req_err) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'h0;
                end
            end
            LDRET: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
            end
            MERGE, WR: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            funct3_q     <= 3'h0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl
// Testbench for lsu_mem_ctrl with a behavioural 4096 x 32 memory
// (synchronous read, read-first). A table of directed requests is run
// back-to-back; hand-written sequences cover per-cycle timing,
// back-to-back issue and reset in the middle of a read-modify-write.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    int checks = 0;
    int errors = 0;

    lsu_mem_ctrl #(.ADDR_WORDS_LOG2(12)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model plus counters of committed writes and response pulses.
    logic [31:0] mem [0:4095];
    logic        preloadEn;
    logic [11:0] preloadIdx;
    logic [31:0] preloadData;
    int          writeCount = 0;
    int          respCount = 0;

    always @(posedge clk) begin
        mem_read_data <= mem[mem_address[11:0]];
        if (preloadEn) begin
            mem[preloadIdx] <= preloadData;
        end else if (mem_write_enable) begin
            mem[mem_address[11:0]] <= mem_write_data;
            writeCount <= writeCount + 1;
        end
        if (resp_valid) respCount <= respCount + 1;
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
        int          expLat;
        int          expWrites;
    } vec_t;

    vec_t vecs[$];

    // Compare and report one value.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Present a request at a negedge and drop it after the accepting edge.
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Wait (bounded) for resp_valid; lat = -1 on timeout.
    task automatic waitResp(output int lat, output logic [31:0] rdata, output logic err);
        lat   = -1;
        rdata = 32'hX;
        err   = 1'bX;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat   = c;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
    endtask

    task automatic addVec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] expRdata,
                          input logic expErr, input int expLat, input int expWrites);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.expRdata = expRdata; v.expErr = expErr; v.expLat = expLat; v.expWrites = expWrites;
        vecs.push_back(v);
    endtask

    initial begin
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          wBase;
        int          rBase;

        // Word 0x40 starts as 0x8899AABB.
        addVec(0, 3'b000, 32'h101, 32'h0, 32'hFFFFFFAA, 0, 3, 0);
        addVec(0, 3'b100, 32'h103, 32'h0, 32'h00000088, 0, 3, 0);
        addVec(0, 3'b001, 32'h102, 32'h0, 32'hFFFF8899, 0, 3, 0);
        addVec(0, 3'b101, 32'h100, 32'h0, 32'h0000AABB, 0, 3, 0);
        addVec(0, 3'b010, 32'h100, 32'h0, 32'h8899AABB, 0, 3, 0);
        addVec(1, 3'b000, 32'h102, 32'h12345655, 32'h0, 0, 3, 1);
        addVec(0, 3'b010, 32'h100, 32'h0, 32'h8855AABB, 0, 3, 0);
        addVec(1, 3'b001, 32'h100, 32'h0000CAFE, 32'h0, 0, 3, 1);
        addVec(0, 3'b010, 32'h100, 32'h0, 32'h8855CAFE, 0, 3, 0);
        addVec(1, 3'b010, 32'h204, 32'hDEADBEEF, 32'h0, 0, 2, 1);
        addVec(0, 3'b010, 32'h204, 32'h0, 32'hDEADBEEF, 0, 3, 0);
        addVec(1, 3'b010, 32'h102, 32'h11111111, 32'h0, 1, 1, 0);
        addVec(0, 3'b001, 32'h001, 32'h0, 32'h0, 1, 1, 0);
        addVec(0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1, 0);
        addVec(1, 3'b100, 32'h100, 32'h22222222, 32'h0, 1, 1, 0);
        addVec(0, 3'b010, 32'h102, 32'h0, 32'h0, 1, 1, 0);
        addVec(0, 3'b101, 32'h103, 32'h0, 32'h0, 1, 1, 0);
        addVec(0, 3'b010, 32'h100, 32'h0, 32'h8855CAFE, 0, 3, 0);
        addVec(0, 3'b000, 32'h100, 32'h0, 32'hFFFFFFFE, 0, 3, 0);
        addVec(0, 3'b101, 32'h102, 32'h0, 32'h00008855, 0, 3, 0);
        addVec(0, 3'b010, 32'h4100, 32'h0, 32'h8855CAFE, 0, 3, 0);
        addVec(0, 3'b100, 32'h101, 32'h0, 32'h000000CA, 0, 3, 0);
        addVec(0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF88, 0, 3, 0);
        addVec(1, 3'b001, 32'h102, 32'hFFFF1357, 32'h0, 0, 3, 1);
        addVec(0, 3'b001, 32'h102, 32'h0, 32'h00001357, 0, 3, 0);

        // Reset and preload.
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'h0;
        req_addr = 32'h0; req_wdata = 32'h0;
        preloadEn = 1'b1; preloadIdx = 12'h040; preloadData = 32'h8899AABB;
        @(negedge clk);
        preloadEn = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_we_async", {31'h0, mem_write_enable}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        checkOutput("rst_resp_err", {31'h0, resp_err}, 32'h0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
        checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h1);

        // Table-driven vectors, issued back-to-back.
        foreach (vecs[i]) begin
            wBase = writeCount;
            applyStimulus(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            waitResp(lat, rdata, err);
            checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].expLat);
            checkOutput($sformatf("v%0d_rdata", i), rdata, vecs[i].expRdata);
            checkOutput($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].expErr});
            checkOutput($sformatf("v%0d_writes", i), writeCount - wBase, vecs[i].expWrites);
        end

        // SW per-cycle timing: write in cycle 1 only, response in cycle 2.
        applyStimulus(1, 3'b010, 32'h208, 32'h01020304);
        @(negedge clk);
        checkOutput("sw_c1_we", {31'h0, mem_write_enable}, 32'h1);
        checkOutput("sw_c1_addr", mem_address, 32'h82);
        checkOutput("sw_c1_wdata", mem_write_data, 32'h01020304);
        checkOutput("sw_c1_resp", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        checkOutput("sw_c2_we", {31'h0, mem_write_enable}, 32'h0);
        checkOutput("sw_c2_resp", {31'h0, resp_valid}, 32'h1);

        // SB per-cycle timing: read, merge-write in cycle 2, respond in cycle 3.
        applyStimulus(1, 3'b000, 32'h209, 32'h000000AA);
        @(negedge clk);
        checkOutput("sb_c1_we", {31'h0, mem_write_enable}, 32'h0);
        checkOutput("sb_c1_addr", mem_address, 32'h82);
        @(negedge clk);
        checkOutput("sb_c2_we", {31'h0, mem_write_enable}, 32'h1);
        checkOutput("sb_c2_addr", mem_address, 32'h82);
        checkOutput("sb_c2_wdata", mem_write_data, 32'h0102AA04);
        @(negedge clk);
        checkOutput("sb_c3_we", {31'h0, mem_write_enable}, 32'h0);
        checkOutput("sb_c3_resp", {31'h0, resp_valid}, 32'h1);

        // Back-to-back: LW accepted in the SW response cycle.
        applyStimulus(1, 3'b010, 32'h300, 32'h5A5A1234);
        rBase = respCount;
        @(negedge clk);
        @(negedge clk);
        checkOutput("b2b_sw_resp", {31'h0, resp_valid}, 32'h1);
        checkOutput("b2b_ready", {31'h0, req_ready}, 32'h1);
        applyStimulus(0, 3'b010, 32'h300, 32'h0);
        waitResp(lat, rdata, err);
        checkOutput("b2b_lw_latency", lat, 3);
        checkOutput("b2b_lw_rdata", rdata, 32'h5A5A1234);
        repeat (3) @(negedge clk);
        checkOutput("b2b_resp_count", respCount - rBase, 2);

        // Reset during the MERGE cycle of an SB.
        applyStimulus(1, 3'b000, 32'h100, 32'h00000077);
        wBase = writeCount;
        rBase = respCount;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstm_we_before", {31'h0, mem_write_enable}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstm_we_dropped", {31'h0, mem_write_enable}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rstm_writes", writeCount - wBase, 0);
        checkOutput("rstm_resps", respCount - rBase, 0);
        checkOutput("rstm_ready", {31'h0, req_ready}, 32'h1);
        applyStimulus(0, 3'b010, 32'h100, 32'h0);
        waitResp(lat, rdata, err);
        checkOutput("rstm_lw_latency", lat, 3);
        checkOutput("rstm_lw_rdata", rdata, 32'h1357CAFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store controller directly upstream of the word-addressed data memory (4096 x 32, synchronous read, one-cycle latency, word-only write, read-first on write cycles).
- Accepts byte, halfword and word load/store requests from the execute stage.
- Converts byte addresses to word indices.
- Performs read-modify-write for SB/SH.
- Sign/zero-extends load data.
- Flags misaligned or illegal accesses without touching memory.

Parameters:
ADDR_WORDS_LOG2, 12, log2 of memory depth in words; word index is req_addr[ADDR_WORDS_LOG2+1:2].

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned or illegal funct3, valid with resp_valid
mem_address  output  32  word index to memory = zero-extended req_addr[ADDR_WORDS_LOG2+1:2]
mem_write_data  output  32  word written to memory
mem_write_enable  output  1  memory write strobe
mem_read_data  input  32  memory registered read output

Behaviour:
- Reset (async, rst_n low): state IDLE; resp_valid, resp_err, resp_rdata = 0; all request registers = 0.
  - mem_write_enable is decoded from state, so it drops to 0 immediately.
  - Reset in any state aborts the operation: no write, no response.
- Accept: req_valid && req_ready at a rising edge.
  - Latches we, funct3, addr, wdata.
  - Address bits above ADDR_WORDS_LOG2+1 are ignored (aliasing allowed).
- Error check at accept:
  - Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0.
  - Illegal funct3: load 011/110/111, store 1xx.
  - On error: next state IDLE, resp_valid=1 and resp_err=1 in cycle 1, resp_rdata=0, no memory access.
- States: IDLE, RD, LDRET, MERGE, WR.
  - IDLE: req_ready=1, mem_write_enable=0. Go to RD (loads, SB, SH) or WR (SW); stay in IDLE on error.
  - RD: mem_address = latched word index, we=0. Next LDRET for loads, MERGE for stores.
  - LDRET: mem_read_data valid.
    - Select byte addr[1:0] or halfword addr[1].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
    - Register into resp_rdata, set resp_valid, go to IDLE.
  - MERGE: mem_write_enable=1, same address.
    - mem_write_data = mem_read_data with byte lane addr[1:0] (SB) or halfword lane addr[1] (SH) replaced by req_wdata[7:0] / [15:0].
    - Set resp_valid, go to IDLE.
  - WR: mem_write_enable=1, mem_write_data = req_wdata. Set resp_valid, go to IDLE.
- mem_address holds the latched index in every non-IDLE state; in IDLE it is don't-care.
- mem_write_data outside MERGE/WR is don't-care but must not be X-propagating; drive latched wdata.
- Latency, with cycle 0 = accept cycle:
  - Loads: resp_valid in cycle 3.
  - SW: cycle 2.
  - SB/SH: cycle 3.
  - Error: cycle 1.
- resp_valid is high exactly one cycle and coincides with IDLE.
  - A new request may be accepted in that same cycle (back-to-back).
- resp_rdata holds until the next response.
- mem_read_data is ignored outside LDRET/MERGE.
- Single outstanding request; no pipelining.
- req_* inputs are ignored while req_ready=0.

Test Plan:
1. Preload word index 0x40 = 0x8899AABB. LB @0x101 -> resp_rdata 0xFFFFFFAA cycle 3. LBU @0x103 -> 0x00000088. LH @0x102 -> 0xFFFF8899. LHU @0x100 -> 0x0000AABB. LW @0x100 -> 0x8899AABB. All with resp_err=0.
2. SB @0x102 wdata 0x12345655 -> one write cycle (cycle 2), mem_write_data 0x8855AABB. SH @0x100 wdata 0x0000CAFE then LW -> 0x8855CAFE.
3. SW @0x204 wdata 0xDEADBEEF -> mem_address 0x81, mem_write_enable in cycle 1 only, resp_valid cycle 2. Following LW returns 0xDEADBEEF.
4. SW @0x102, LH @0x001, load funct3=011 -> resp_valid+resp_err in cycle 1, resp_rdata 0, mem_write_enable never asserted, memory unchanged.
5. Back-to-back: SW then LW issued in the resp_valid cycle of the SW -> second accepted that cycle, correct data, no lost or duplicate response.
6. rst_n low during MERGE of SB @0x100 -> mem_write_enable drops immediately, word unchanged, no resp_valid, state IDLE with req_ready=1 after release.
